// File: rtl/l1cache_pkg.sv
// rtl/l1cache_pkg.sv - shared types and constants for the L1 cache port arbiter
// Contents: FSM state enum, address/data widths, cache response codes.
package l1cache_pkg;

    localparam int ADDR_W = 20;
    localparam int DATA_W = 32;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin grant selection
// Ports:
//   i_req     request vector, one bit per requester
//   i_last_id index of the most recently served requester
//   o_grant   one-hot grant (zero when no request)
//   o_idx     index of the granted requester
//   o_any     at least one request present
module rr_arbiter #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   i_req,
    input  logic [IDW-1:0] i_last_id,
    output logic [N-1:0]   o_grant,
    output logic [IDW-1:0] o_idx,
    output logic           o_any
);

    localparam logic [IDW:0] NW = (IDW+1)'(N);

    // One extra bit holds last_id + k before the mod-N wrap (max 2N-1).
    logic [IDW:0]   w_sum;
    logic [IDW-1:0] w_cand;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_sum   = '0;
        w_cand  = '0;
        // Scan last_id+1 .. last_id+N so the previous winner has lowest priority.
        for (int k = 1; k <= N; k++) begin
            w_sum = {1'b0, i_last_id} + (IDW+1)'(k);
            if (w_sum >= NW) begin
                w_sum = w_sum - NW;
            end
            w_cand = w_sum[IDW-1:0];
            if (!o_any && i_req[w_cand]) begin
                o_any           = 1'b1;
                o_grant[w_cand] = 1'b1;
                o_idx           = w_cand;
            end
        end
    end

endmodule

// File: rtl/l1cache_port_arb.sv
// rtl/l1cache_port_arb.sv - round-robin arbiter sharing one L1 cache port among requesters
// Ports:
//   clk, rstn                         clock, synchronous active-low reset
//   req_valid/req_write/addr/wdata    per-requester request, packed by requester index
//   req_ready                         one-hot acceptance pulse
//   rsp_valid/rsp_rdata/rsp_hit/err   one-hot completion pulse with payload
//   c_data_addr/c_wdata/c_*valid      cache command, live for one cycle
//   c_rvalid/c_rdata/c_*_hit/c_*_resp cache status, sampled only while waiting
module l1cache_port_arb
    import l1cache_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_hit,
    output logic                      rsp_err,
    output logic [ADDR_W-1:0]         c_data_addr,
    output logic [DATA_W-1:0]         c_wdata,
    output logic                      c_awvalid,
    output logic                      c_wvalid,
    output logic                      c_arvalid,
    input  logic                      c_rvalid,
    input  logic [DATA_W-1:0]         c_rdata,
    input  logic                      c_w_hit,
    input  logic                      c_r_hit,
    input  logic [1:0]                c_w_resp,
    input  logic [1:0]                c_r_resp
);

    localparam int         IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [8:0] TO9 = 9'(TIMEOUT);

    state_t             r_state;
    logic [IDW-1:0]     r_last_id;
    logic [IDW-1:0]     r_id;
    logic               r_write;
    logic [7:0]         r_cnt;
    logic [ADDR_W-1:0]  r_c_addr;
    logic [DATA_W-1:0]  r_c_wdata;
    logic               r_c_aw;
    logic               r_c_w;
    logic               r_c_ar;
    logic [NUM_REQ-1:0] r_rsp_valid;
    logic [DATA_W-1:0]  r_rsp_rdata;
    logic               r_rsp_hit;
    logic               r_rsp_err;

    logic [NUM_REQ-1:0] w_grant;
    logic [IDW-1:0]     w_idx;
    logic               w_any;
    logic               w_done;
    logic               w_hit;
    logic               w_timeout;
    logic               w_unused;

    logic [ADDR_W-1:0]  w_addr  [NUM_REQ];
    logic [DATA_W-1:0]  w_wdata [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign w_addr[g]  = req_addr[g*ADDR_W +: ADDR_W];
        assign w_wdata[g] = req_wdata[g*DATA_W +: DATA_W];
    end

    rr_arbiter #(
        .N   (NUM_REQ),
        .IDW (IDW)
    ) u_rr (
        .i_req     (req_valid),
        .i_last_id (r_last_id),
        .o_grant   (w_grant),
        .o_idx     (w_idx),
        .o_any     (w_any)
    );

    // Acceptance is a same-cycle handshake; suppressed while reset is asserted
    // because the grant would not be taken on that edge.
    assign req_ready = (rstn && r_state == IDLE) ? w_grant : '0;

    assign w_done    = r_write ? (c_w_hit || (c_w_resp != RESP_OKAY)) : c_rvalid;
    assign w_hit     = r_write ? c_w_hit : c_r_hit;
    // r_cnt holds (WAIT cycle number - 1), so this fires on WAIT cycle TIMEOUT.
    assign w_timeout = ({1'b0, r_cnt} + 9'd1) == TO9;
    // Read response code carries no information the response payload reports.
    assign w_unused  = ^c_r_resp;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state     <= IDLE;
            r_last_id   <= IDW'(NUM_REQ - 1);
            r_id        <= '0;
            r_write     <= 1'b0;
            r_cnt       <= '0;
            r_c_addr    <= '0;
            r_c_wdata   <= '0;
            r_c_aw      <= 1'b0;
            r_c_w       <= 1'b0;
            r_c_ar      <= 1'b0;
            r_rsp_valid <= '0;
            r_rsp_rdata <= '0;
            r_rsp_hit   <= 1'b0;
            r_rsp_err   <= 1'b0;
        end else begin
            // Command and response registers are pulses: cleared unless set below.
            r_c_addr    <= '0;
            r_c_wdata   <= '0;
            r_c_aw      <= 1'b0;
            r_c_w       <= 1'b0;
            r_c_ar      <= 1'b0;
            r_rsp_valid <= '0;
            r_rsp_rdata <= '0;
            r_rsp_hit   <= 1'b0;
            r_rsp_err   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_id      <= w_idx;
                        r_write   <= req_write[w_idx];
                        r_c_addr  <= w_addr[w_idx];
                        r_c_wdata <= w_wdata[w_idx];
                        r_c_aw    <= req_write[w_idx];
                        r_c_w     <= req_write[w_idx];
                        r_c_ar    <= !req_write[w_idx];
                        r_state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_cnt   <= '0;
                    r_state <= WAIT;
                end
                WAIT: begin
                    // Completion is checked first so it beats a coincident timeout.
                    if (w_done || w_timeout) begin
                        r_rsp_valid <= NUM_REQ'(1) << r_id;
                        r_rsp_rdata <= (w_done && !r_write) ? c_rdata : '0;
                        r_rsp_hit   <= w_done && w_hit;
                        r_rsp_err   <= !w_done;
                        r_state     <= RESP;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                RESP: begin
                    r_last_id <= r_id;
                    r_state   <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_hit     = r_rsp_hit;
    assign rsp_err     = r_rsp_err;
    assign c_data_addr = r_c_addr;
    assign c_wdata     = r_c_wdata;
    assign c_awvalid   = r_c_aw;
    assign c_wvalid    = r_c_w;
    assign c_arvalid   = r_c_ar;

endmodule

// File: tb/tb_l1cache_port_arb.sv
// tb/tb_l1cache_port_arb.sv - self-checking bench for l1cache_port_arb
module tb_l1cache_port_arb;

    localparam int N  = 4;
    localparam int TO = 15;

    typedef struct packed {
        logic [N-1:0] id;
        logic [31:0]  rdata;
        logic         hit;
        logic         err;
    } exp_t;

    logic            clk = 1'b0;
    logic            rstn;
    logic [N-1:0]    req_valid, req_write, req_ready, rsp_valid;
    logic [N*20-1:0] req_addr;
    logic [N*32-1:0] req_wdata;
    logic [31:0]     rsp_rdata, c_wdata, c_rdata;
    logic            rsp_hit, rsp_err;
    logic [19:0]     c_data_addr;
    logic            c_awvalid, c_wvalid, c_arvalid;
    logic            c_rvalid, c_w_hit, c_r_hit;
    logic [1:0]      c_w_resp, c_r_resp;

    exp_t         exp_q[$];
    logic [N-1:0] grant_q[$];
    int           n_cmp = 0;
    int           n_err = 0;

    always #5 clk = ~clk;

    l1cache_port_arb #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata), .rsp_hit(rsp_hit), .rsp_err(rsp_err),
        .c_data_addr(c_data_addr), .c_wdata(c_wdata),
        .c_awvalid(c_awvalid), .c_wvalid(c_wvalid), .c_arvalid(c_arvalid),
        .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .c_w_hit(c_w_hit), .c_r_hit(c_r_hit),
        .c_w_resp(c_w_resp), .c_r_resp(c_r_resp)
    );

    task step;
        @(negedge clk);
    endtask

    task clear_inputs;
        req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        c_rvalid = 1'b0; c_rdata = '0; c_w_hit = 1'b0; c_r_hit = 1'b0;
        c_w_resp = 2'b00; c_r_resp = 2'b00;
    endtask

    task test_reset;
        rstn = 1'b0;
        req_valid = '1;
        step; step; #1;
        n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL rst_ready: got %b expected 0000", req_ready); end
        n_cmp++; if ({c_awvalid, c_wvalid, c_arvalid} !== 3'b000) begin n_err++; $display("FAIL rst_cmd: got %b expected 000", {c_awvalid, c_wvalid, c_arvalid}); end
        n_cmp++; if ({rsp_valid, rsp_rdata, rsp_hit, rsp_err, c_data_addr, c_wdata} !== '0) begin n_err++; $display("FAIL rst_outs: got %h expected 0", {rsp_valid, rsp_rdata, rsp_hit, rsp_err, c_data_addr, c_wdata}); end
        req_valid = '0;
        step;
        rstn = 1'b1;
    endtask

    task test_single_read;
        exp_t e;
        req_valid = 4'b0001; req_write = '0; req_addr[0 +: 20] = 20'h00104;
        exp_q.push_back({4'b0001, 32'hDEADBEEF, 1'b1, 1'b0});
        #1;
        n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL rd_ready: got %b expected 0001", req_ready); end
        step; req_valid = '0; #1;
        n_cmp++; if ({c_arvalid, c_awvalid, c_wvalid, c_data_addr} !== {3'b100, 20'h00104}) begin n_err++; $display("FAIL rd_cmd: got %h expected %h", {c_arvalid, c_awvalid, c_wvalid, c_data_addr}, {3'b100, 20'h00104}); end
        step;
        n_cmp++; if (c_arvalid !== 1'b0) begin n_err++; $display("FAIL rd_cmd_once: got %b expected 0", c_arvalid); end
        c_rvalid = 1'b1; c_rdata = 32'hDEADBEEF; c_r_hit = 1'b1;
        step;
        c_rvalid = 1'b0; c_rdata = '0; c_r_hit = 1'b0;
        e = exp_q.pop_front();
        n_cmp++; if ({rsp_valid, rsp_rdata, rsp_hit, rsp_err} !== e) begin n_err++; $display("FAIL rd_rsp: got %h expected %h", {rsp_valid, rsp_rdata, rsp_hit, rsp_err}, e); end
        step;
        n_cmp++; if (rsp_valid !== 4'b0000) begin n_err++; $display("FAIL rd_rsp_once: got %b expected 0000", rsp_valid); end
    endtask

    task test_round_robin;
        exp_t         e;
        logic [N-1:0] g;
        int           ng, last_c;
        bit           drop;
        rstn = 1'b0;
        req_valid = '1; req_write = '0;
        c_rvalid = 1'b1; c_rdata = 32'h1111_0000; c_r_hit = 1'b1;
        grant_q = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        step; step;
        rstn = 1'b1;
        ng = 0; last_c = 0; drop = 1'b0;
        for (int c = 0; c < 80; c++) begin
            #1;
            if (req_ready != '0) begin
                if (grant_q.size() == 0) begin
                    n_cmp++; n_err++; $display("FAIL rr_extra_grant: got %b expected none", req_ready);
                end else begin
                    g = grant_q.pop_front();
                    n_cmp++; if (req_ready !== g) begin n_err++; $display("FAIL rr_grant: got %b expected %b", req_ready, g); end
                    if (ng > 0) begin
                        n_cmp++; if (c - last_c < 4) begin n_err++; $display("FAIL rr_spacing: got %0d expected >=4", c - last_c); end
                    end
                    exp_q.push_back({g, 32'h1111_0000, 1'b1, 1'b0});
                end
                last_c = c;
                ng++;
                if (ng == 5) drop = 1'b1;
            end
            if (rsp_valid != '0) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_err++; $display("FAIL rr_rsp_extra: got %b expected none", rsp_valid);
                end else begin
                    e = exp_q.pop_front();
                    n_cmp++; if ({rsp_valid, rsp_rdata, rsp_hit, rsp_err} !== e) begin n_err++; $display("FAIL rr_rsp: got %h expected %h", {rsp_valid, rsp_rdata, rsp_hit, rsp_err}, e); end
                end
            end
            if (ng == 5 && exp_q.size() == 0) break;
            step;
            if (drop) begin req_valid = '0; drop = 1'b0; end
        end
        n_cmp++; if (ng != 5 || exp_q.size() != 0) begin n_err++; $display("FAIL rr_done: got %0d grants expected 5 with no pending responses", ng); end
        exp_q.delete();
        clear_inputs();
        step;
    endtask

    task test_write;
        exp_t e;
        req_valid = 4'b0100; req_write = 4'b0100;
        req_addr[2*20 +: 20] = 20'hFFFFC; req_wdata[2*32 +: 32] = 32'h12345678;
        exp_q.push_back({4'b0100, 32'h0, 1'b1, 1'b0});
        #1;
        n_cmp++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL wr_ready: got %b expected 0100", req_ready); end
        step; req_valid = '0; #1;
        n_cmp++; if ({c_awvalid, c_wvalid, c_arvalid, c_data_addr, c_wdata} !== {3'b110, 20'hFFFFC, 32'h12345678}) begin n_err++; $display("FAIL wr_cmd: got %h expected %h", {c_awvalid, c_wvalid, c_arvalid, c_data_addr, c_wdata}, {3'b110, 20'hFFFFC, 32'h12345678}); end
        step;
        n_cmp++; if ({c_awvalid, c_wvalid} !== 2'b00) begin n_err++; $display("FAIL wr_cmd_once: got %b expected 00", {c_awvalid, c_wvalid}); end
        c_w_hit = 1'b1;
        step;
        c_w_hit = 1'b0;
        e = exp_q.pop_front();
        n_cmp++; if ({rsp_valid, rsp_rdata, rsp_hit, rsp_err} !== e) begin n_err++; $display("FAIL wr_rsp: got %h expected %h", {rsp_valid, rsp_rdata, rsp_hit, rsp_err}, e); end
        step;
        // Write completed by a non-zero response code on the third WAIT cycle.
        req_valid = 4'b0010; req_write = 4'b0010;
        req_addr[1*20 +: 20] = 20'h00010; req_wdata[1*32 +: 32] = 32'h0BADCAFE;
        exp_q.push_back({4'b0010, 32'h0, 1'b0, 1'b0});
        #1;
        n_cmp++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL wr2_ready: got %b expected 0010", req_ready); end
        step; req_valid = '0; req_write = '0;
        step; step; step;
        n_cmp++; if (rsp_valid !== 4'b0000) begin n_err++; $display("FAIL wr2_early: got %b expected 0000", rsp_valid); end
        c_w_resp = 2'b10;
        step;
        c_w_resp = 2'b00;
        e = exp_q.pop_front();
        n_cmp++; if ({rsp_valid, rsp_rdata, rsp_hit, rsp_err} !== e) begin n_err++; $display("FAIL wr2_rsp: got %h expected %h", {rsp_valid, rsp_rdata, rsp_hit, rsp_err}, e); end
        step;
    endtask

    task test_timeout;
        exp_t e;
        for (int pass = 0; pass < 2; pass++) begin
            req_valid = 4'b1000; req_write = '0; req_addr[3*20 +: 20] = 20'h0ABC0;
            if (pass == 0) exp_q.push_back({4'b1000, 32'h0, 1'b0, 1'b1});
            else           exp_q.push_back({4'b1000, 32'hA5A5A5A5, 1'b1, 1'b0});
            #1;
            n_cmp++; if (req_ready !== 4'b1000) begin n_err++; $display("FAIL to_ready: got %b expected 1000", req_ready); end
            step; req_valid = '0;
            for (int k = 2; k <= 16; k++) step;
            n_cmp++; if (rsp_valid !== 4'b0000) begin n_err++; $display("FAIL to_early: got %b expected 0000", rsp_valid); end
            if (pass == 1) begin c_rvalid = 1'b1; c_rdata = 32'hA5A5A5A5; c_r_hit = 1'b1; end
            step;
            c_rvalid = 1'b0; c_rdata = '0; c_r_hit = 1'b0;
            e = exp_q.pop_front();
            n_cmp++; if ({rsp_valid, rsp_rdata, rsp_hit, rsp_err} !== e) begin n_err++; $display("FAIL to_rsp%0d: got %h expected %h", pass, {rsp_valid, rsp_rdata, rsp_hit, rsp_err}, e); end
            step;
        end
    endtask

    task test_stray;
        exp_t e;
        c_rvalid = 1'b1; c_rdata = 32'hBAD0BAD0; c_r_hit = 1'b1;
        step;
        c_rvalid = 1'b0; c_rdata = '0; c_r_hit = 1'b0;
        n_cmp++; if (rsp_valid !== 4'b0000) begin n_err++; $display("FAIL stray_idle: got %b expected 0000", rsp_valid); end
        req_valid = 4'b0001; req_write = '0; req_addr[0 +: 20] = 20'h00200;
        exp_q.push_back({4'b0001, 32'hCAFEF00D, 1'b0, 1'b0});
        #1;
        n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL stray_ready: got %b expected 0001", req_ready); end
        step; req_valid = '0;
        c_rvalid = 1'b1; c_rdata = 32'hBAD0BAD0; c_r_hit = 1'b1;
        step;
        c_rvalid = 1'b0; c_rdata = '0; c_r_hit = 1'b0;
        n_cmp++; if (rsp_valid !== 4'b0000) begin n_err++; $display("FAIL stray_issue: got %b expected 0000", rsp_valid); end
        step;
        n_cmp++; if (rsp_valid !== 4'b0000) begin n_err++; $display("FAIL stray_wait1: got %b expected 0000", rsp_valid); end
        c_rvalid = 1'b1; c_rdata = 32'hCAFEF00D;
        step;
        c_rvalid = 1'b0; c_rdata = '0;
        e = exp_q.pop_front();
        n_cmp++; if ({rsp_valid, rsp_rdata, rsp_hit, rsp_err} !== e) begin n_err++; $display("FAIL stray_rsp: got %h expected %h", {rsp_valid, rsp_rdata, rsp_hit, rsp_err}, e); end
        step;
    endtask

    task test_reset_wait;
        exp_t e;
        req_valid = 4'b0010; req_write = '0; req_addr[1*20 +: 20] = 20'h00300;
        #1;
        n_cmp++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL rw_ready: got %b expected 0010", req_ready); end
        step; req_valid = '0;
        step; rstn = 1'b0;
        step;
        n_cmp++; if ({rsp_valid, c_arvalid} !== 5'b0) begin n_err++; $display("FAIL rw_abort: got %b expected 00000", {rsp_valid, c_arvalid}); end
        rstn = 1'b1;
        req_valid = 4'b0011;
        exp_q.push_back({4'b0001, 32'h0F0F0F0F, 1'b1, 1'b0});
        #1;
        n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL rw_regrant: got %b expected 0001", req_ready); end
        step; req_valid = '0;
        n_cmp++; if (rsp_valid !== 4'b0000) begin n_err++; $display("FAIL rw_no_rsp: got %b expected 0000", rsp_valid); end
        step;
        c_rvalid = 1'b1; c_rdata = 32'h0F0F0F0F; c_r_hit = 1'b1;
        step;
        c_rvalid = 1'b0; c_rdata = '0; c_r_hit = 1'b0;
        e = exp_q.pop_front();
        n_cmp++; if ({rsp_valid, rsp_rdata, rsp_hit, rsp_err} !== e) begin n_err++; $display("FAIL rw_rsp: got %h expected %h", {rsp_valid, rsp_rdata, rsp_hit, rsp_err}, e); end
        step;
    endtask

    initial begin
        clear_inputs();
        rstn = 1'b0;
        step;
        test_reset();
        test_single_read();
        test_round_robin();
        test_write();
        test_timeout();
        test_stray();
        test_reset_wait();
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL sb_drain: got %0d pending expected 0", exp_q.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/l1cache_port_arb.md
L1CACHE_PORT_ARB -- requirements
Module: l1cache_port_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing the cache port (2..8).
REQ-002 SHALL have parameter TIMEOUT, default 15, maximum WAIT cycles before an error response (1..255).
REQ-003 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port rstn  input  1  reset, synchronous, active-low.
REQ-005 SHALL have ports req_valid / req_write  input  NUM_REQ each  per-requester request and write flag (1 = write).
REQ-006 SHALL have ports req_addr  input  NUM_REQ*20 and req_wdata  input  NUM_REQ*32, packed, requester i at slice i.
REQ-007 SHALL have port req_ready  output  NUM_REQ  one-cycle acceptance pulse, one-hot.
REQ-008 SHALL have port rsp_valid  output  NUM_REQ  one-cycle completion pulse, one-hot.
REQ-009 SHALL have ports rsp_rdata  output  32, rsp_hit  output  1, rsp_err  output  1  response payload, valid only with rsp_valid.
REQ-010 SHALL have ports c_data_addr  output  20, c_wdata  output  32, c_awvalid / c_wvalid / c_arvalid  output  1  cache command.
REQ-011 SHALL have ports c_rvalid  input  1, c_rdata  input  32, c_w_hit / c_r_hit  input  1, c_w_resp / c_r_resp  input  2  cache status.

Function
REQ-012 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP.
REQ-013 IDLE: if any req_valid, SHALL grant by round-robin starting at (last_id+1) mod NUM_REQ, latch addr/wdata/write/id, pulse req_ready[id], go to ISSUE; else stay.
REQ-014 ISSUE: SHALL drive latched address/data for exactly one cycle, with c_awvalid=c_wvalid=1 for writes or c_arvalid=1 for reads; go to WAIT.
REQ-015 WAIT: write completes on c_w_hit=1 or c_w_resp!=0; read completes on c_rvalid=1; on completion latch c_rdata (reads), hit (c_w_hit or c_r_hit), err=0; go to RESP.
REQ-016 WAIT: SHALL count cycles from 1; if count reaches TIMEOUT without completion, set err=1, hit=0, rdata=0, go to RESP.
REQ-017 Completion and timeout in the same cycle: completion SHALL win, err=0.
REQ-018 RESP: SHALL pulse rsp_valid[id] with latched payload for one cycle, set last_id=id, return to IDLE.
REQ-019 Minimum latency: accept cycle T, command T+1, completion sampled T+2, rsp_valid T+3; next grant no earlier than T+4.
REQ-020 c_* command outputs SHALL be 0 outside ISSUE; rsp_* outputs SHALL be 0 outside RESP.
REQ-021 Cache status inputs outside WAIT SHALL be ignored.
REQ-022 req_valid held high after acceptance SHALL be treated as a new request at the next IDLE; req_valid dropping before acceptance SHALL be ignored.
REQ-023 Counter SHALL be 8 bits and clear on entry to WAIT.

Reset
REQ-024 rstn=0 at a clock edge SHALL force IDLE, last_id=NUM_REQ-1 (first grant goes to requester 0), counter=0, and all outputs 0.
REQ-025 Reset mid-transaction SHALL abandon it with no rsp_valid.

Structure
REQ-026 Package l1cache_pkg SHALL hold the state enum, ADDR_W=20, DATA_W=32, and the resp code constants.
REQ-027 Round-robin grant logic SHALL be one sub-module, rr_arbiter (request vector, last_id -> one-hot grant, index), purely combinational.

Verification
REQ-028 Single read: req_valid[0], addr 0x00104, cache c_rvalid=1 with c_rdata=0xDEADBEEF, c_r_hit=1 at T+2 -> rsp_valid[0] at T+3, rdata 0xDEADBEEF, hit=1, err=0.
REQ-029 All four requesters valid continuously from reset -> grants in order 0,1,2,3,0, each spaced at least 4 cycles.
REQ-030 Write from requester 2, addr 0xFFFFC, wdata 0x12345678 -> c_awvalid=c_wvalid=1 with exact addr/data for one cycle only; c_w_hit=1 -> rsp_valid[2], hit=1.
REQ-031 Read with cache silent, TIMEOUT=15 -> rsp_valid at cycle 15 of WAIT with err=1, hit=0, rdata=0; a c_rvalid pulse on that same cycle instead -> err=0.
REQ-032 rstn=0 during WAIT -> no rsp_valid, FSM IDLE, next grant goes to requester 0.
REQ-033 c_rvalid pulse during IDLE, then normal read -> stray pulse ignored, read returns correct data.
